// File: rtl/ddr3_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_chk_pkg
// Purpose  : Command/violation encodings and default DDR3 timing values shared
//            by the timing checker and the controller.
// Revision : 1.0
// ============================================================================
package ddr3_chk_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    typedef enum logic [3:0] {
        VIOL_NONE  = 4'd0,
        VIOL_TRFC  = 4'd1,
        VIOL_STATE = 4'd2,
        VIOL_TRP   = 4'd3,
        VIOL_TRAS  = 4'd4,
        VIOL_TRCD  = 4'd5,
        VIOL_TRRD  = 4'd6,
        VIOL_TCCD  = 4'd7
    } viol_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } bank_state_e;

    localparam int C_NUM_BANKS = 8;
    localparam int C_BANK_W    = 3;
    localparam int C_T_RCD     = 5;
    localparam int C_T_RP      = 5;
    localparam int C_T_RAS     = 15;
    localparam int C_T_RRD     = 4;
    localparam int C_T_CCD     = 4;
    localparam int C_T_RFC     = 44;
    localparam int C_CNT_W     = 8;

    function automatic logic is_rdwr(input logic [2:0] c);
        return (c == CMD_RD) || (c == CMD_WR);
    endfunction

endpackage : ddr3_chk_pkg
`default_nettype wire

// File: rtl/ddr3_bank_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_bank_tracker
// Purpose  : One bank's IDLE/ACTIVE state plus its tRCD/tRP/tRAS timers.
// Revision : 1.0
// ============================================================================
module ddr3_bank_tracker
    import ddr3_chk_pkg::*;
#(
    parameter int T_RCD = C_T_RCD,
    parameter int T_RP  = C_T_RP,
    parameter int T_RAS = C_T_RAS,
    parameter int CNT_W = C_CNT_W
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_act,
    input  logic i_pre,
    output logic o_open,
    output logic o_rcd_zero,
    output logic o_rp_zero,
    output logic o_ras_zero
);

    localparam logic [CNT_W-1:0] c_RCD_LD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] c_RP_LD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] c_RAS_LD = CNT_W'(T_RAS - 1);

    bank_state_e      r_state;
    bank_state_e      w_state_nxt;
    logic             w_rp_load;
    logic [CNT_W-1:0] r_rcd;
    logic [CNT_W-1:0] r_rp;
    logic [CNT_W-1:0] r_ras;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PRE only arms tRP when it actually closes the row.
    always_comb begin
        w_state_nxt = r_state;
        w_rp_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_act) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (i_pre) begin
                    w_state_nxt = ST_IDLE;
                    w_rp_load   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rcd <= '0;
            r_rp  <= '0;
            r_ras <= '0;
        end else begin
            if (i_act) begin
                r_rcd <= c_RCD_LD;
                r_ras <= c_RAS_LD;
            end else begin
                if (r_rcd != '0) r_rcd <= r_rcd - CNT_W'(1);
                if (r_ras != '0) r_ras <= r_ras - CNT_W'(1);
            end
            if (w_rp_load) begin
                r_rp <= c_RP_LD;
            end else if (r_rp != '0) begin
                r_rp <= r_rp - CNT_W'(1);
            end
        end
    end

    assign o_open     = (r_state == ST_ACTIVE);
    assign o_rcd_zero = (r_rcd == '0);
    assign o_rp_zero  = (r_rp == '0);
    assign o_ras_zero = (r_ras == '0);

endmodule : ddr3_bank_tracker
`default_nettype wire

// File: rtl/ddr3_timing_checker.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_timing_checker
// Purpose  : Watches the DDR3 command bus and flags the first JEDEC timing or
//            state rule each command breaks.
// Revision : 1.0
// ============================================================================
module ddr3_timing_checker
    import ddr3_chk_pkg::*;
#(
    parameter int NUM_BANKS = C_NUM_BANKS,
    parameter int BANK_W    = C_BANK_W,
    parameter int T_RCD     = C_T_RCD,
    parameter int T_RP      = C_T_RP,
    parameter int T_RAS     = C_T_RAS,
    parameter int T_RRD     = C_T_RRD,
    parameter int T_CCD     = C_T_CCD,
    parameter int T_RFC     = C_T_RFC,
    parameter int CNT_W     = C_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd,
    input  logic [BANK_W-1:0]    cmd_bank,
    input  logic                 clear_err,
    output logic                 violation,
    output logic [3:0]           viol_code,
    output logic [BANK_W-1:0]    viol_bank,
    output logic [15:0]          err_count,
    output logic [NUM_BANKS-1:0] bank_open
);

    localparam logic [CNT_W-1:0] c_RRD_LD = CNT_W'(T_RRD - 1);
    localparam logic [CNT_W-1:0] c_CCD_LD = CNT_W'(T_CCD - 1);
    localparam logic [CNT_W-1:0] c_RFC_LD = CNT_W'(T_RFC - 1);

    logic                 w_act, w_rdwr, w_pre, w_ref, w_chk, w_viol;
    logic [NUM_BANKS-1:0] w_hit, w_open, w_rcd_zero, w_rp_zero, w_ras_zero;
    logic                 w_sel_open, w_sel_rcd_zero, w_sel_rp_zero, w_sel_ras_zero;
    viol_e                w_code;
    logic [CNT_W-1:0]     r_rrd, r_ccd, r_rfc;
    logic                 r_viol;
    logic [3:0]           r_code;
    logic [BANK_W-1:0]    r_bank;
    logic [15:0]          r_err;

    assign w_act  = cmd_valid && (cmd == CMD_ACT);
    assign w_rdwr = cmd_valid && is_rdwr(cmd);
    assign w_pre  = cmd_valid && (cmd == CMD_PRE);
    assign w_ref  = cmd_valid && (cmd == CMD_REF);
    assign w_chk  = w_act || w_rdwr || w_pre || w_ref;

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
            assign w_hit[g] = (cmd_bank == BANK_W'(g));
            ddr3_bank_tracker #(
                .T_RCD (T_RCD),
                .T_RP  (T_RP),
                .T_RAS (T_RAS),
                .CNT_W (CNT_W)
            ) u_bank (
                .clock      (clock),
                .reset_n    (reset_n),
                .i_act      (w_act && w_hit[g]),
                .i_pre      (w_pre && w_hit[g]),
                .o_open     (w_open[g]),
                .o_rcd_zero (w_rcd_zero[g]),
                .o_rp_zero  (w_rp_zero[g]),
                .o_ras_zero (w_ras_zero[g])
            );
        end
    endgenerate

    assign w_sel_open     = w_open[cmd_bank];
    assign w_sel_rcd_zero = w_rcd_zero[cmd_bank];
    assign w_sel_rp_zero  = w_rp_zero[cmd_bank];
    assign w_sel_ras_zero = w_ras_zero[cmd_bank];

    // First matching rule wins; later rules are masked once one fires.
    always_comb begin
        w_code = VIOL_NONE;
        if (w_chk) begin
            if (r_rfc != '0) begin
                w_code = VIOL_TRFC;
            end else if ((w_act && w_sel_open) || (w_rdwr && !w_sel_open) ||
                         (w_ref && (|w_open))) begin
                w_code = VIOL_STATE;
            end else if ((w_act && !w_sel_rp_zero) || (w_ref && !(&w_rp_zero))) begin
                w_code = VIOL_TRP;
            end else if (w_pre && w_sel_open && !w_sel_ras_zero) begin
                w_code = VIOL_TRAS;
            end else if (w_rdwr && !w_sel_rcd_zero) begin
                w_code = VIOL_TRCD;
            end else if (w_act && (r_rrd != '0)) begin
                w_code = VIOL_TRRD;
            end else if (w_rdwr && (r_ccd != '0)) begin
                w_code = VIOL_TCCD;
            end
        end
    end

    assign w_viol = (w_code != VIOL_NONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rrd <= '0;
            r_ccd <= '0;
            r_rfc <= '0;
        end else begin
            if (w_act)              r_rrd <= c_RRD_LD;
            else if (r_rrd != '0)   r_rrd <= r_rrd - CNT_W'(1);
            if (w_rdwr)             r_ccd <= c_CCD_LD;
            else if (r_ccd != '0)   r_ccd <= r_ccd - CNT_W'(1);
            if (w_ref)              r_rfc <= c_RFC_LD;
            else if (r_rfc != '0)   r_rfc <= r_rfc - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_viol <= 1'b0;
            r_code <= 4'd0;
            r_bank <= '0;
            r_err  <= 16'd0;
        end else begin
            r_viol <= w_viol;
            r_code <= w_code;
            r_bank <= (w_viol && !w_ref) ? cmd_bank : '0;
            if (clear_err) begin
                r_err <= w_viol ? 16'd1 : 16'd0;
            end else if (w_viol && (r_err != 16'hFFFF)) begin
                r_err <= r_err + 16'd1;
            end
        end
    end

    assign violation = r_viol;
    assign viol_code = r_code;
    assign viol_bank = r_bank;
    assign err_count = r_err;
    assign bank_open = w_open;

endmodule : ddr3_timing_checker
`default_nettype wire

// File: tb/tb_ddr3_timing_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_timing_checker
// Purpose  : Directed and randomized checks of ddr3_timing_checker against a
//            timestamp-based reference model.
// Revision : 1.0
// ============================================================================
module tb_ddr3_timing_checker;

    localparam int NB   = 8;
    localparam int FAR  = -1000000;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic [2:0]    cmd_bank = 3'd0;
    logic          clear_err = 1'b0;
    logic          violation;
    logic [3:0]    viol_code;
    logic [2:0]    viol_bank;
    logic [15:0]   err_count;
    logic [NB-1:0] bank_open;

    int checks = 0;
    int failures = 0;

    // Model state: times of the last relevant commands, in cycles.
    int now;
    int last_act[NB];
    int last_pre[NB];
    bit open_m[NB];
    int last_any_act, last_rdwr, last_ref, cnt_m;
    bit exp_v;
    int exp_code, exp_bank;

    ddr3_timing_checker dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_bank  (cmd_bank),
        .clear_err (clear_err),
        .violation (violation),
        .viol_code (viol_code),
        .viol_bank (viol_bank),
        .err_count (err_count),
        .bank_open (bank_open)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, now);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            last_act[i] = FAR;
            last_pre[i] = FAR;
            open_m[i]   = 1'b0;
        end
        last_any_act = FAR;
        last_rdwr    = FAR;
        last_ref     = FAR;
        cnt_m        = 0;
    endtask

    function automatic logic [NB-1:0] open_vec();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = open_m[i];
        return v;
    endfunction

    // Drives one bus cycle, predicts its outcome, then compares one cycle later.
    task automatic step(input bit v, input int c, input int b, input bit clr);
        bit act, rdwr, pre, rf, any_open, any_rp;
        @(negedge clock);
        cmd_valid = v;
        cmd       = 3'(c);
        cmd_bank  = 3'(b);
        clear_err = clr;
        act  = v && (c == 1);
        rdwr = v && (c == 2 || c == 3);
        pre  = v && (c == 4);
        rf   = v && (c == 5);
        any_open = 1'b0;
        any_rp   = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (open_m[i]) any_open = 1'b1;
            if (now - last_pre[i] < 5) any_rp = 1'b1;
        end
        exp_code = 0;
        if (act || rdwr || pre || rf) begin
            if (now - last_ref < 44)                                       exp_code = 1;
            else if ((act && open_m[b]) || (rdwr && !open_m[b]) || (rf && any_open)) exp_code = 2;
            else if ((act && (now - last_pre[b] < 5)) || (rf && any_rp))  exp_code = 3;
            else if (pre && open_m[b] && (now - last_act[b] < 15))        exp_code = 4;
            else if (rdwr && (now - last_act[b] < 5))                     exp_code = 5;
            else if (act && (now - last_any_act < 4))                     exp_code = 6;
            else if (rdwr && (now - last_rdwr < 4))                       exp_code = 7;
        end
        exp_v    = (exp_code != 0);
        exp_bank = rf ? 0 : b;
        if (act) begin
            open_m[b] = 1'b1; last_act[b] = now; last_any_act = now;
        end
        if (rdwr) last_rdwr = now;
        if (pre && open_m[b]) begin
            open_m[b] = 1'b0; last_pre[b] = now;
        end
        if (rf) last_ref = now;
        if (clr)        cnt_m = exp_v ? 1 : 0;
        else if (exp_v) cnt_m = (cnt_m == 65535) ? 65535 : cnt_m + 1;
        now++;
        @(posedge clock);
        #1;
        chk("violation", 32'(violation), 32'(exp_v));
        if (exp_v) begin
            chk("viol_code", 32'(viol_code), 32'(exp_code));
            chk("viol_bank", 32'(viol_bank), 32'(exp_bank));
        end
        chk("err_count", 32'(err_count), 32'(cnt_m));
        chk("bank_open", 32'(bank_open), 32'(open_vec()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_violation"}, 32'(violation), 32'd0);
        chk({tag, "_code"},      32'(viol_code), 32'd0);
        chk({tag, "_bank"},      32'(viol_bank), 32'd0);
        chk({tag, "_err"},       32'(err_count), 32'd0);
        chk({tag, "_open"},      32'(bank_open), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        clear_err = 1'b0;
        @(negedge clock);
        model_reset();
        zero_outputs("reset");
        reset_n = 1'b1;
    endtask

    initial begin
        now = 0;
        model_reset();
        apply_reset();

        // Legal open/read/close/reopen sequence on bank 2.
        step(1, 1, 2, 0);
        chk("legal_open_c1", 32'(bank_open[2]), 32'd1);
        idle(4);
        step(1, 2, 2, 0);
        idle(9);
        chk("legal_open_c15", 32'(bank_open[2]), 32'd1);
        step(1, 4, 2, 0);
        chk("legal_open_c16", 32'(bank_open[2]), 32'd0);
        idle(4);
        step(1, 1, 2, 0);
        chk("legal_err", 32'(err_count), 32'd0);

        // tRCD: RD four cycles after ACT.
        apply_reset();
        step(1, 1, 1, 0);
        idle(3);
        step(1, 2, 1, 0);
        chk("trcd_viol", 32'(violation), 32'd1);
        chk("trcd_code", 32'(viol_code), 32'd5);
        chk("trcd_bank", 32'(viol_bank), 32'd1);
        chk("trcd_err",  32'(err_count), 32'd1);

        // Priority: STATE beats TRRD; plain TRRD across banks.
        apply_reset();
        step(1, 1, 0, 0);
        idle(1);
        step(1, 1, 0, 0);
        chk("prio_state", 32'(viol_code), 32'd2);
        apply_reset();
        step(1, 1, 3, 0);
        idle(2);
        step(1, 1, 4, 0);
        chk("prio_trrd", 32'(viol_code), 32'd6);

        // tRFC boundary.
        apply_reset();
        step(1, 5, 0, 0);
        idle(42);
        step(1, 1, 0, 0);
        chk("trfc_43_code", 32'(viol_code), 32'd1);
        apply_reset();
        step(1, 5, 0, 0);
        idle(43);
        step(1, 1, 0, 0);
        chk("trfc_44_viol", 32'(violation), 32'd0);

        // err_count clear behaviour.
        apply_reset();
        step(1, 2, 0, 0);
        step(1, 2, 0, 0);
        chk("clr_pre", 32'(err_count), 32'd2);
        step(0, 0, 0, 1);
        chk("clr_alone", 32'(err_count), 32'd0);
        step(1, 2, 0, 1);
        chk("clr_with_viol", 32'(err_count), 32'd1);

        // Async reset mid-tRAS with a TRAS violation on the outputs.
        apply_reset();
        step(1, 1, 0, 0);
        step(1, 4, 0, 0);
        chk("ras_pending_code", 32'(viol_code), 32'd4);
        #2 reset_n = 1'b0;
        #1 zero_outputs("async");
        @(negedge clock);
        model_reset();
        reset_n = 1'b1;
        step(1, 1, 0, 0);
        chk("post_reset_act", 32'(violation), 32'd0);

        // Randomized traffic.
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            int r, c;
            r = int'($urandom_range(0, 99));
            if (r < 20)      c = 1;
            else if (r < 40) c = 2;
            else if (r < 55) c = 3;
            else if (r < 75) c = 4;
            else if (r < 77) c = 5;
            else if (r < 80) c = int'($urandom_range(6, 7));
            else             c = 0;
            step(($urandom_range(0, 99) < 55), c, int'($urandom_range(0, 7)),
                 ($urandom_range(0, 59) == 0));
            if (i == 2000) apply_reset();
        end

        // Saturation: 65535 STATE violations, then one more.
        apply_reset();
        for (int i = 0; i < 65535; i++) step(1, 2, i % NB, 0);
        chk("sat_reach", 32'(err_count), 32'hFFFF);
        step(1, 3, 5, 0);
        chk("sat_hold", 32'(err_count), 32'hFFFF);
        step(0, 0, 0, 1);
        chk("sat_clear", 32'(err_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ddr3_timing_checker
`default_nettype wire

// File: doc/ddr3_timing_checker.md
Name: ddr3_timing_checker

Overview:
- Command-side counterpart to the controller's delay counter. The controller counts down delays to *obey* JEDEC timing; this block sits on the memory-model side of the DDR3 command bus and *checks* that every issued command obeyed it.
- Tracks per-bank open/idle state and per-bank/global timing counters, then flags the first rule each command breaks.
- Output feeds the scoreboard and error-status logic.

Parameters:
- NUM_BANKS, 8, number of DDR3 banks; power of two.
- BANK_W, 3, bank address width, log2(NUM_BANKS).
- T_RCD, 5, ACT to RD/WR same bank, clocks.
- T_RP, 5, PRE to ACT same bank, clocks.
- T_RAS, 15, ACT to PRE same bank, clocks.
- T_RRD, 4, ACT to ACT any bank, clocks.
- T_CCD, 4, RD/WR to RD/WR any bank, clocks.
- T_RFC, 44, REF to any non-NOP command, clocks.
- CNT_W, 8, timer width; must hold the largest T_* value.

Ports:
- clock  in  1  single clock for the block.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  a command is present on the bus this cycle.
- cmd  in  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE, 5=REF; 6 and 7 are reserved.
- cmd_bank  in  BANK_W  target bank; ignored for REF and NOP.
- clear_err  in  1  synchronous clear of err_count.
- violation  out  1  one-cycle pulse, registered.
- viol_code  out  4  violation type, valid while violation=1.
- viol_bank  out  BANK_W  bank of the offending command.
- err_count  out  16  saturating total of violations.
- bank_open  out  NUM_BANKS  per-bank open flag.

Behaviour:
- Reset:
  - All outputs go to 0, all banks go IDLE, all timers go to 0.
  - Reset is asynchronous and may arrive mid-operation; checking resumes on the first clock after release.
- Timer model:
  - Each timer is a saturating down-counter.
  - A command loads its timer with T_x-1 in the cycle it is issued (cycle t).
  - The timer decrements every cycle while nonzero.
  - A dependent command at cycle t+k is legal iff the timer reads 0, i.e. k >= T_x.
  - T_x=1 means back-to-back commands are legal.
- Per-bank timers: rcd[b], rp[b], ras[b].
- Global timers: rrd, ccd, rfc.
- Per-bank FSM, two states:
  - IDLE --ACT--> ACTIVE.
  - ACTIVE --PRE--> IDLE.
  - bank_open[b] = (state == ACTIVE).
- Command effects, applied whether or not the command is legal (the checker tracks the actual bus):
  - ACT: bank goes ACTIVE; loads rcd[b], ras[b], rrd.
  - RD/WR: loads ccd; no state change.
  - PRE on an ACTIVE bank: bank goes IDLE; loads rp[b].
  - PRE on an IDLE bank: legal, no effect.
  - REF: loads rfc.
  - NOP, reserved codes, or cmd_valid=0: no effect, no check.
- viol_code values, checked in this priority order (the first match wins; one code per command):
  - 1 TRFC: rfc != 0 and cmd != NOP.
  - 2 STATE: ACT to an ACTIVE bank; RD/WR to an IDLE bank; REF with any bank open.
  - 3 TRP: ACT with rp[b] != 0; REF with any rp != 0.
  - 4 TRAS: PRE to an ACTIVE bank with ras[b] != 0.
  - 5 TRCD: RD/WR with rcd[b] != 0.
  - 6 TRRD: ACT with rrd != 0.
  - 7 TCCD: RD/WR with ccd != 0.
  - 0 means none.
- Latency: violation, viol_code and viol_bank are registered and appear exactly 1 cycle after the offending command.
- For REF, viol_bank = 0.
- err_count:
  - Increments by 1 on each violation and saturates at 0xFFFF.
  - clear_err alone sets it to 0.
  - clear_err in the same cycle as a violation increment sets it to 1.
- Timers keep decrementing while cmd_valid=0.

Decomposition:
- Package ddr3_chk_pkg holds:
  - the cmd_e enum (NOP..REF);
  - the viol_e enum (NONE..TCCD);
  - default timing localparams, shared with the controller so both ends agree.
- Sub-module ddr3_bank_tracker, instantiated NUM_BANKS times, holds one bank's FSM plus its rcd/rp/ras timers and exports state and timer-zero flags.
- The top level holds the global timers, priority encoder, output registers and error counter.

Test Plan:
- Legal sequence: ACT b2 @0, RD b2 @5, PRE b2 @15, ACT b2 @20 -> violation never asserts; bank_open[2] is 1 from cycle 1 to 15 and 0 from cycle 16.
- tRCD: ACT b1 @0, RD b1 @4 -> violation=1 @5, viol_code=5, viol_bank=1, err_count=1.
- Priority: ACT b0 @0, ACT b0 @2 -> code=2 (STATE), not 6 (TRRD); ACT b3 @0, ACT b4 @3 -> code=6.
- tRFC: REF @0 with all banks idle, ACT b0 @43 -> code=1 @44; ACT b0 @44 instead -> no violation.
- Saturation/clear:
  - Force err_count to 0xFFFF, cause a violation -> stays 0xFFFF.
  - clear_err alone -> 0.
  - clear_err coincident with a violation -> 1.
- Async reset: assert reset_n=0 mid-tRAS with violation pending -> all outputs and bank_open go to 0 immediately; after release, ACT b0 produces no violation.
